dcache_data_ctrl: RTL

Controller that sits directly upstream of the 64×128-bit cache data array and is its sole driver. It serves single-word core reads and byte-masked core writes, and assembles four 32-bit refill beats into a 128-bit line written in one array cycle. All array control (CS, OE, active-low WEB, A, DI) comes from this block, and array read data (DO) returns through it.

---
 rtl/dcache_data_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dcache_data_ctrl.sv
// Data-array controller for a 64x128-bit cache line store: core word reads, byte-masked writes, 4-beat refills.
// Optional macro DCACHE_FILL_BYPASS_EN returns the missed word alongside the refill line write.
module dcache_data_ctrl #(
  parameter int INDEX_W = 6,
  parameter int WORD_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_write,
  input  logic [INDEX_W-1:0]    core_index,
  input  logic [1:0]            core_offset,
  input  logic [WORD_W/8-1:0]   core_wstrb,
  input  logic [WORD_W-1:0]     core_wdata,
  output logic                  core_ready,
  output logic                  core_rvalid,
  output logic [WORD_W-1:0]     core_rdata,
  input  logic                  fill_start,
  input  logic [INDEX_W-1:0]    fill_index,
  input  logic [1:0]            fill_offset,
  input  logic                  fill_valid,
  input  logic [WORD_W-1:0]     fill_data,
  output logic                  fill_ready,
  output logic                  fill_done,
  output logic                  CS,
  output logic                  OE,
  output logic [WORD_W/2-1:0]   WEB,
  output logic [INDEX_W-1:0]    A,
  output logic [4*WORD_W-1:0]   DI,
  input  logic [4*WORD_W-1:0]   DO
);

  localparam int LINE_W = 4 * WORD_W;
  localparam int BPW    = WORD_W / 8;

  typedef enum logic [1:0] {IDLE, READ, FILL, FILL_WR} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           count_reg, count_next;
  logic [WORD_W-1:0]    buf_reg [4];
  logic [INDEX_W-1:0]   fill_index_reg;
  logic [1:0]           fill_offset_reg;
  logic [1:0]           rd_offset_reg;

  logic [LINE_W-1:0]    line_data;
  logic [LINE_W-1:0]    wr_line;
  logic [LINE_W/8-1:0]  wr_web;
  logic [WORD_W-1:0]    do_words [4];

  logic fill_take, core_take, beat_take;

  // Fill requests pre-empt a simultaneous core request.
  assign fill_take = (state_reg == IDLE) && fill_start;
  assign core_take = (state_reg == IDLE) && !fill_start && core_req;
  assign beat_take = (state_reg == FILL) && fill_valid;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign line_data[gi*WORD_W +: WORD_W] = buf_reg[gi];
      assign wr_line[gi*WORD_W +: WORD_W]   = core_wdata;
      assign do_words[gi]                   = DO[gi*WORD_W +: WORD_W];
      assign wr_web[gi*BPW +: BPW]          = (core_offset == 2'(gi)) ? ~core_wstrb : '1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      count_reg       <= 2'd0;
      fill_index_reg  <= '0;
      fill_offset_reg <= 2'd0;
      rd_offset_reg   <= 2'd0;
      for (int i = 0; i < 4; i++) buf_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (fill_take) begin
        fill_index_reg  <= fill_index;
        fill_offset_reg <= fill_offset;
      end
      if (core_take && !core_write) rd_offset_reg <= core_offset;
      if (beat_take) buf_reg[count_reg] <= fill_data;
    end
  end

`ifndef DCACHE_FILL_BYPASS_EN
  logic unused_fill_offset;
  assign unused_fill_offset = &{1'b0, fill_offset_reg};
`endif

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    core_ready  = 1'b0;
    core_rvalid = 1'b0;
    core_rdata  = '0;
    fill_ready  = 1'b0;
    fill_done   = 1'b0;
    CS          = 1'b0;
    OE          = 1'b0;
    WEB         = '1;
    A           = '0;
    DI          = '0;
    // Reset masks every output so an aborted read or fill leaves no trace.
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          core_ready = !fill_start;
          if (fill_start) begin
            state_next = FILL;
            count_next = 2'd0;
          end else if (core_req) begin
            CS = 1'b1;
            A  = core_index;
            if (core_write) begin
              DI  = wr_line;
              WEB = wr_web;
            end else begin
              OE         = 1'b1;
              state_next = READ;
            end
          end
        end
        READ: begin
          core_rvalid = 1'b1;
          core_rdata  = do_words[rd_offset_reg];
          state_next  = IDLE;
        end
        FILL: begin
          fill_ready = 1'b1;
          if (fill_valid) begin
            count_next = count_reg + 2'd1;
            if (count_reg == 2'd3) state_next = FILL_WR;
          end
        end
        FILL_WR: begin
          CS         = 1'b1;
          WEB        = '0;
          A          = fill_index_reg;
          DI         = line_data;
          fill_done  = 1'b1;
`ifdef DCACHE_FILL_BYPASS_EN
          core_rvalid = 1'b1;
          core_rdata  = buf_reg[fill_offset_reg];
`endif
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
